// File: rtl/ddr_wr_burst_arbiter.sv
// Round-robin arbiter sharing one DDR write-burst port among NUM_REQ buffer controllers.
// Optional burst watchdog is enabled by defining WR_ARB_TIMEOUT_EN.
module ddr_wr_burst_arbiter #(
  parameter real TCQ            = 0.1,
  parameter int  NUM_REQ        = 4,
  parameter int  ADDR_WIDTH     = 30,
  parameter int  MEM_DATA_BITS  = 256,
  parameter int  TIMEOUT_CYCLES = 4096
) (
  input  logic                             ddr_clk_i,
  input  logic                             ddr_rst_i,
  input  logic [NUM_REQ-1:0]               req_wr_req_i,
  input  logic [NUM_REQ*8-1:0]             req_wr_len_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_wr_addr_i,
  input  logic [NUM_REQ*MEM_DATA_BITS-1:0] req_wr_data_i,
  output logic [NUM_REQ-1:0]               req_fifo_rd_o,
  output logic [NUM_REQ-1:0]               req_wr_finish_o,
  output logic                             wr_ddr_req_o,
  output logic [7:0]                       wr_ddr_len_o,
  output logic [ADDR_WIDTH-1:0]            wr_ddr_addr_o,
  input  logic                             ddr_fifo_rd_req_i,
  output logic [MEM_DATA_BITS-1:0]         wr_ddr_data_o,
  input  logic                             wr_ddr_finish_i,
  output logic [NUM_REQ-1:0]               arb_grant_o,
  output logic                             arb_busy_o,
  output logic                             timeout_err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536 || TCQ < 0.0)
  begin : g_cfg_check
    $error("ddr_wr_burst_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_BURST, ARB_RELEASE} arb_state_t;

  arb_state_t              r_state;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           r_gidx;
  logic [NUM_REQ-1:0]      r_grant;
  logic [7:0]              r_len;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_ddr_req;
  logic                    r_busy;

  logic                    w_win_vld;
  logic [IW-1:0]           w_win_idx;
  logic [IW-1:0]           w_scan;
  logic [NUM_REQ-1:0]      w_win_grant;
  logic [7:0]              w_win_len;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic                    w_in_burst;
  logic                    w_timeout;
  logic                    w_done;

  // First requester at or above the rotating pointer wins, wrapping modulo NUM_REQ.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan = IW'((int'(r_ptr) + i) % NUM_REQ);
      if (!w_win_vld && req_wr_req_i[w_scan]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_scan;
      end
    end
  end

  always_comb begin
    w_win_len   = '0;
    w_win_addr  = '0;
    w_win_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == IW'(i)) begin
        w_win_len      = req_wr_len_i[8*i +: 8];
        w_win_addr     = req_wr_addr_i[ADDR_WIDTH*i +: ADDR_WIDTH];
        w_win_grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ddr_data_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) wr_ddr_data_o = req_wr_data_i[MEM_DATA_BITS*i +: MEM_DATA_BITS];
    end
  end

  assign w_in_burst      = (r_state == ARB_BURST);
  assign w_done          = w_in_burst && (wr_ddr_finish_i || w_timeout);
  assign req_fifo_rd_o   = (w_in_burst && ddr_fifo_rd_req_i) ? r_grant : '0;
  assign req_wr_finish_o = w_done ? r_grant : '0;

`ifdef WR_ARB_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_to_err;

  assign w_timeout = w_in_burst && (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Counter restarts on every burst; the error flag only clears on reset.
  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else begin
      r_to_cnt <= w_in_burst ? r_to_cnt + 16'd1 : 16'd0;
      if (w_timeout && !wr_ddr_finish_i) r_to_err <= 1'b1;
    end
  end

  assign timeout_err_o = r_to_err;
`else
  assign w_timeout     = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge ddr_clk_i) begin
    if (ddr_rst_i) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_len     <= '0;
      r_addr    <= '0;
      r_ddr_req <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_win_vld) begin
            r_state <= ARB_GRANT;
            r_busy  <= 1'b1;
            r_gidx  <= w_win_idx;
            r_grant <= w_win_grant;
            r_len   <= w_win_len;
            r_addr  <= w_win_addr;
          end
        end
        ARB_GRANT: begin
          r_state   <= ARB_BURST;
          r_ddr_req <= 1'b1;
        end
        ARB_BURST: begin
          if (ddr_fifo_rd_req_i) r_ddr_req <= 1'b0;
          if (w_done) begin
            r_state   <= ARB_RELEASE;
            r_ddr_req <= 1'b0;
            r_grant   <= '0;
            r_len     <= '0;
            r_addr    <= '0;
          end
        end
        ARB_RELEASE: begin
          r_state <= ARB_IDLE;
          r_busy  <= 1'b0;
          r_ptr   <= (r_gidx == IW'(NUM_REQ - 1)) ? '0 : r_gidx + IW'(1);
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign wr_ddr_req_o  = r_ddr_req;
  assign wr_ddr_len_o  = r_len;
  assign wr_ddr_addr_o = r_addr;
  assign arb_grant_o   = r_grant;
  assign arb_busy_o    = r_busy;

endmodule

// File: tb/tb_ddr_wr_burst_arbiter.sv
// Directed self-checking bench for ddr_wr_burst_arbiter (default and WR_ARB_TIMEOUT_EN builds).
module tb_ddr_wr_burst_arbiter;
  localparam int NR = 4;
  localparam int AW = 30;
  localparam int DB = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*8-1:0]   len;
  logic [NR*AW-1:0]  addr;
  logic [NR*DB-1:0]  data;
  logic [NR-1:0]     fifo_rd;
  logic [NR-1:0]     fin_o;
  logic              ddr_req;
  logic [7:0]        ddr_len;
  logic [AW-1:0]     ddr_addr;
  logic              rd;
  logic [DB-1:0]     ddr_data;
  logic              fin;
  logic [NR-1:0]     grant;
  logic              busy;
  logic              to_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ddr_wr_burst_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .MEM_DATA_BITS(DB), .TIMEOUT_CYCLES(64)
  ) dut (
    .ddr_clk_i(clk), .ddr_rst_i(rst),
    .req_wr_req_i(req), .req_wr_len_i(len), .req_wr_addr_i(addr), .req_wr_data_i(data),
    .req_fifo_rd_o(fifo_rd), .req_wr_finish_o(fin_o),
    .wr_ddr_req_o(ddr_req), .wr_ddr_len_o(ddr_len), .wr_ddr_addr_o(ddr_addr),
    .ddr_fifo_rd_req_i(rd), .wr_ddr_data_o(ddr_data), .wr_ddr_finish_i(fin),
    .arb_grant_o(grant), .arb_busy_o(busy), .timeout_err_o(to_err)
  );

  function automatic logic [DB-1:0] pat(input int k);
    return {8{32'hA5A5_0000 + 32'(k)}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rd = 1'b0; fin = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; len = '0; addr = '0; rd = 1'b0; fin = 1'b0;
    for (int k = 0; k < NR; k++) data[k*DB +: DB] = pat(k);
    cyc(); cyc();
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_req", 64'(ddr_req), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_len", 64'(ddr_len), 64'h0);
    chk("rst_addr", 64'(ddr_addr), 64'h0);
    chkd("rst_data", ddr_data, '0);
    chk("rst_toerr", 64'(to_err), 64'h0);
    rst = 1'b0;

    // single requester 1, 128 beats
    req = 4'b0010; len[8 +: 8] = 8'd128; addr[AW +: AW] = 30'h80;
    cyc();
    chk("t1_grant", 64'(grant), 64'h2);
    chk("t1_req_lat1", 64'(ddr_req), 64'h0);
    chk("t1_busy", 64'(busy), 64'h1);
    cyc();
    chk("t1_req_lat2", 64'(ddr_req), 64'h1);
    chk("t1_len", 64'(ddr_len), 64'd128);
    chk("t1_addr", 64'(ddr_addr), 64'h80);
    chkd("t1_data", ddr_data, pat(1));
    req = '0;
    for (int b = 0; b < 128; b++) begin
      rd = 1'b1; #1;
      chk("t1_fifo_rd", 64'(fifo_rd), 64'h2);
      cyc();
    end
    rd = 1'b0; #1;
    chk("t1_fifo_idle", 64'(fifo_rd), 64'h0);
    chk("t1_req_clr", 64'(ddr_req), 64'h0);
    fin = 1'b1; #1;
    chk("t1_finish", 64'(fin_o), 64'h2);
    cyc();
    fin = 1'b0;
    chk("t1_rel_grant", 64'(grant), 64'h0);
    chk("t1_rel_busy", 64'(busy), 64'h1);
    cyc();
    chk("t1_idle_busy", 64'(busy), 64'h0);
    rd = 1'b1; fin = 1'b1; #1;
    chk("idle_rd_ignored", 64'(fifo_rd), 64'h0);
    chk("idle_fin_ignored", 64'(fin_o), 64'h0);
    cyc();
    chk("idle_stays", 64'(busy), 64'h0);
    rd = 1'b0; fin = 1'b0;

    // req0 + req2 after reset, then req0 + req3 with pointer at 3
    do_reset();
    req = 4'b0101; len[0 +: 8] = 8'd16; addr[0 +: AW] = 30'h1000;
    len[16 +: 8] = 8'd32; addr[2*AW +: AW] = 30'h2000;
    cyc();
    chk("t2_first", 64'(grant), 64'h1);
    cyc();
    chk("t2_len0", 64'(ddr_len), 64'd16);
    chk("t2_addr0", 64'(ddr_addr), 64'h1000);
    fin = 1'b1; #1;
    chk("t2_fin0", 64'(fin_o), 64'h1);
    cyc();
    fin = 1'b0; req = 4'b0100;
    cyc();
    cyc();
    chk("t2_second", 64'(grant), 64'h4);
    chk("t2_gap_lo", 64'(ddr_req), 64'h0);
    cyc();
    chk("t2_gap_hi", 64'(ddr_req), 64'h1);
    chk("t2_addr2", 64'(ddr_addr), 64'h2000);
    chkd("t2_data2", ddr_data, pat(2));
    fin = 1'b1; #1;
    chk("t2_fin2", 64'(fin_o), 64'h4);
    cyc();
    fin = 1'b0; req = 4'b1001;
    cyc();
    cyc();
    chk("t2_ptr3", 64'(grant), 64'h8);
    cyc();
    fin = 1'b1; cyc(); fin = 1'b0; req = 4'b0001;
    cyc(); cyc();
    chk("t2_wrap", 64'(grant), 64'h1);

    // all requesters held high: rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t3_rotate", 64'(grant), 64'(4'b0001 << (k % 4)));
      cyc();
      fin = 1'b1; #1;
      chk("t3_fin", 64'(fin_o), 64'(4'b0001 << (k % 4)));
      cyc();
      fin = 1'b0;
      cyc();
    end

    // frozen addr/len while requester changes them mid-burst
    do_reset();
    req = 4'b0001; len[0 +: 8] = 8'd8; addr[0 +: AW] = 30'h100;
    cyc(); cyc();
    chk("t4_addr_pre", 64'(ddr_addr), 64'h100);
    addr[0 +: AW] = 30'h200; len[0 +: 8] = 8'd99; req = '0;
    cyc();
    chk("t4_addr_held", 64'(ddr_addr), 64'h100);
    chk("t4_len_held", 64'(ddr_len), 64'd8);
    fin = 1'b1; cyc(); fin = 1'b0; cyc();

    // reset at beat 64 of a 128-beat burst
    req = 4'b0001; len[0 +: 8] = 8'd128; addr[0 +: AW] = 30'h40;
    cyc(); cyc();
    req = '0;
    for (int b = 0; b < 64; b++) begin
      rd = 1'b1; cyc();
    end
    rst = 1'b1; #1;
    chk("t5_no_fin_pre", 64'(fin_o), 64'h0);
    cyc();
    rst = 1'b0; rd = 1'b0;
    chk("t5_grant", 64'(grant), 64'h0);
    chk("t5_req", 64'(ddr_req), 64'h0);
    chk("t5_busy", 64'(busy), 64'h0);
    req = 4'b0001; len[0 +: 8] = 8'd4; addr[0 +: AW] = 30'h300;
    cyc();
    chk("t5_regrant", 64'(grant), 64'h1);
    cyc();
    chk("t5_req2", 64'(ddr_req), 64'h1);
    chk("t5_addr2", 64'(ddr_addr), 64'h300);
    req = '0; fin = 1'b1; #1;
    chk("t5_fin", 64'(fin_o), 64'h1);
    cyc();
    fin = 1'b0; cyc();

    // finish withheld: watchdog fires at count 64, or FSM waits indefinitely
    req = 4'b0010;
    cyc(); cyc();
    req = '0;
`ifdef WR_ARB_TIMEOUT_EN
    for (int c = 0; c < 63; c++) cyc();
    chk("t6_to_fin", 64'(fin_o), 64'h2);
    chk("t6_err_pre", 64'(to_err), 64'h0);
    cyc();
    chk("t6_err", 64'(to_err), 64'h1);
    chk("t6_req_clr", 64'(ddr_req), 64'h0);
    cyc(); cyc(); cyc();
    chk("t6_err_sticky", 64'(to_err), 64'h1);
    chk("t6_idle", 64'(busy), 64'h0);
    do_reset();
    chk("t6_err_rst", 64'(to_err), 64'h0);
`else
    for (int c = 0; c < 100; c++) cyc();
    chk("t6_stay_busy", 64'(busy), 64'h1);
    chk("t6_stay_grant", 64'(grant), 64'h2);
    chk("t6_no_fin", 64'(fin_o), 64'h0);
    chk("t6_no_err", 64'(to_err), 64'h0);
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
